// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Handshaked ALU with registered result and flags. Single-cycle
//             logic/arithmetic ops plus iterative ROT (orientation quarter
//             turns) and MUL (shift-add, one multiplier bit per cycle).
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zf,
  output logic             cf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_INC  = 4'd4;
  localparam logic [3:0] OP_DEC  = 4'd5;
  localparam logic [3:0] OP_COMP = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_ROT  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               is_mul_q, is_mul_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // MUL: {partial product high half, remaining multiplier bits}.
  // ROT: low WIDTH bits hold the operand being turned.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               wrap_q, wrap_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zf_q, zf_d;
  logic               cf_q, cf_d;
  logic               err_q, err_d;

  logic               accept;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     inc_sum;
  logic [WIDTH-1:0]   sc_out;
  logic               sc_zf, sc_cf, sc_err;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   rot_next;
  logic               rot_wrap;

  // Reset masks in_ready so nothing is accepted on a reset edge.
  assign in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
  assign err       = err_q;

  // Single-cycle result and flags, computed from the operands being accepted.
  always_comb begin
    add_sum = {1'b0, in0} + {1'b0, in1};
    inc_sum = {1'b0, in0} + (WIDTH+1)'(1);
    sc_out  = '0;
    sc_cf   = 1'b0;
    sc_err  = 1'b0;
    case (op)
      OP_AND:  sc_out = in0 & in1;
      OP_OR:   sc_out = in0 | in1;
      OP_ADD: begin
        sc_out = add_sum[WIDTH-1:0];
        sc_cf  = add_sum[WIDTH];
      end
      OP_SUB: begin
        // Absolute difference; carry flags that in1 was the larger operand.
        if (in1 > in0) begin
          sc_out = in1 - in0;
          sc_cf  = 1'b1;
        end else begin
          sc_out = in0 - in1;
        end
      end
      OP_INC: begin
        sc_out = inc_sum[WIDTH-1:0];
        sc_cf  = inc_sum[WIDTH];
      end
      OP_DEC: begin
        sc_out = in0 - WIDTH'(1);
        sc_cf  = (in0 == '0);
      end
      OP_COMP: sc_out = in0;
      OP_PASS: sc_out = in0;
      OP_ROT:  sc_out = '0;
      OP_MUL:  sc_out = '0;
      default: sc_err = 1'b1;
    endcase
    // COMP reports equality in zf; illegal ops force zf low despite out=0.
    if (op == OP_COMP) begin
      sc_zf = (in0 == in1);
    end else if (sc_err) begin
      sc_zf = 1'b0;
    end else begin
      sc_zf = (sc_out == '0);
    end
  end

  // Next-state, iteration datapath and result capture.
  always_comb begin
    state_d  = state_q;
    is_mul_d = is_mul_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    wrap_d   = wrap_q;
    out_d    = out_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    err_d    = err_q;

    // One shift-add step: add multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One quarter turn of the 2-bit orientation field.
    rot_next = {acc_q[WIDTH-1:2], acc_q[1:0] + 2'd1};
    rot_wrap = wrap_q || (acc_q[1:0] == 2'b11);

    case (state_q)
      S_IDLE: ;
      S_BUSY: begin
        if (is_mul_q) begin
          acc_d = mul_next;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            out_d   = mul_next[WIDTH-1:0];
            zf_d    = (mul_next[WIDTH-1:0] == '0);
            cf_d    = (mul_next[2*WIDTH-1:WIDTH] != '0);
            err_d   = 1'b0;
          end
        end else begin
          acc_d  = {acc_q[2*WIDTH-1:WIDTH], rot_next};
          wrap_d = rot_wrap;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            out_d   = rot_next;
            zf_d    = (rot_next == '0);
            cf_d    = rot_wrap;
            err_d   = 1'b0;
          end
        end
        cnt_d = cnt_q - CW'(1);
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new accept (from IDLE, or retiring DONE) overrides the above.
    if (accept) begin
      if (op == OP_MUL) begin
        state_d  = S_BUSY;
        is_mul_d = 1'b1;
        cnt_d    = CW'(WIDTH - 1);
        acc_d    = {{WIDTH{1'b0}}, in1};
        mcand_d  = in0;
      end else if ((op == OP_ROT) && (in0[1:0] != 2'd0)) begin
        state_d  = S_BUSY;
        is_mul_d = 1'b0;
        cnt_d    = CW'(in0[1:0] - 2'd1);
        acc_d    = {{WIDTH{1'b0}}, in1};
        wrap_d   = 1'b0;
      end else if (op == OP_ROT) begin
        state_d = S_DONE;
        out_d   = in1;
        zf_d    = (in1 == '0);
        cf_d    = 1'b0;
        err_d   = 1'b0;
      end else begin
        state_d = S_DONE;
        out_d   = sc_out;
        zf_d    = sc_zf;
        cf_d    = sc_cf;
        err_d   = sc_err;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      is_mul_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      wrap_q   <= 1'b0;
      out_q    <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_mul_q <= is_mul_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      wrap_q   <= wrap_d;
      out_q    <= out_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Directed vector table plus hand-written handshake, backpressure
//             and reset sequences for alu_seq at WIDTH=8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       zf;
  logic       cf;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] o;
    logic       zf;
    logic       cf;
    logic       err;
    int         lat;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in0       (in0),
    .in1       (in1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .zf        (zf),
    .cf        (cf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one vector, scramble inputs after accept, measure latency.
  task automatic run_vec(input int i);
    vec_t v;
    int   lat;
    v = vecs[i];
    chk($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
    op = v.op; in0 = v.a; in1 = v.b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; op = ~v.op; in0 = ~v.a; in1 = ~v.b;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk($sformatf("v%0d.busy_in_ready", i), {31'd0, in_ready}, 32'd0);
      tick();
      lat++;
    end
    chk($sformatf("v%0d.latency", i), lat, v.lat);
    chk($sformatf("v%0d.out", i), {24'd0, dout}, {24'd0, v.o});
    chk($sformatf("v%0d.zf", i), {31'd0, zf}, {31'd0, v.zf});
    chk($sformatf("v%0d.cf", i), {31'd0, cf}, {31'd0, v.cf});
    chk($sformatf("v%0d.err", i), {31'd0, err}, {31'd0, v.err});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    //            op     a      b      out    zf    cf    err   lat
    vecs[0]  = '{4'd2,  8'd200, 8'd100, 8'd44,  1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{4'd3,  8'd5,   8'd9,   8'd4,   1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{4'd3,  8'd9,   8'd5,   8'd4,   1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'd4,  8'd255, 8'd0,   8'd0,   1'b1, 1'b1, 1'b0, 1};
    vecs[4]  = '{4'd5,  8'd0,   8'd0,   8'd255, 1'b0, 1'b1, 1'b0, 1};
    vecs[5]  = '{4'd6,  8'd7,   8'd7,   8'd7,   1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'd6,  8'd7,   8'd8,   8'd7,   1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'd0,  8'hF0,  8'h0F,  8'h00,  1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'd1,  8'hF0,  8'h0F,  8'hFF,  1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'd7,  8'h5A,  8'h33,  8'h5A,  1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{4'd8,  8'd3,   8'hA6,  8'hA5,  1'b0, 1'b1, 1'b0, 4};
    vecs[11] = '{4'd8,  8'd0,   8'h37,  8'h37,  1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{4'd8,  8'd1,   8'h02,  8'h03,  1'b0, 1'b0, 1'b0, 2};
    vecs[13] = '{4'd9,  8'd15,  8'd17,  8'd255, 1'b0, 1'b0, 1'b0, 9};
    vecs[14] = '{4'd9,  8'd16,  8'd16,  8'd0,   1'b1, 1'b1, 1'b0, 9};
    vecs[15] = '{4'd12, 8'd33,  8'd44,  8'd0,   1'b0, 1'b0, 1'b1, 1};
    vecs[16] = '{4'd9,  8'd255, 8'd255, 8'd1,   1'b0, 1'b1, 1'b0, 9};
    vecs[17] = '{4'd2,  8'd0,   8'd0,   8'd0,   1'b1, 1'b0, 1'b0, 1};
    vecs[18] = '{4'd5,  8'd1,   8'd0,   8'd0,   1'b1, 1'b0, 1'b0, 1};
    vecs[19] = '{4'd15, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 1};
    vecs[20] = '{4'd3,  8'd7,   8'd7,   8'd0,   1'b1, 1'b0, 1'b0, 1};
    vecs[21] = '{4'd8,  8'd2,   8'h03,  8'h01,  1'b0, 1'b1, 1'b0, 3};

    rst = 1'b1; in_valid = 1'b0; op = 4'd0; in0 = 8'd0; in1 = 8'd0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out", {24'd0, dout}, 32'd0);
    chk("rst.flags", {29'd0, zf, cf, err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      run_vec(i);
    end

    // Retire without a new accept: out_valid drops, result is retained.
    tick();
    chk("retire.out_valid", {31'd0, out_valid}, 32'd0);
    chk("retire.out_kept", {24'd0, dout}, 32'd1);
    chk("retire.cf_kept", {31'd0, cf}, 32'd1);

    // Backpressure: result held 5 cycles while a competing op waits.
    out_ready = 1'b0;
    op = 4'd2; in0 = 8'd3; in1 = 8'd4; in_valid = 1'b1;
    tick();
    op = 4'd2; in0 = 8'd1; in1 = 8'd1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d.out_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d.out", c), {24'd0, dout}, 32'd7);
      chk($sformatf("bp%0d.zf_cf", c), {30'd0, zf, cf}, 32'd0);
      chk($sformatf("bp%0d.in_ready", c), {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp.next_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp.next_out", {24'd0, dout}, 32'd2);

    // Back-to-back stream of ten ADDs, one result per cycle in order.
    for (int i = 0; i < 10; i++) begin
      op = 4'd2; in0 = 8'(i * 30); in1 = 8'(i * 7 + 1); in_valid = 1'b1;
      e = 8'(i * 37 + 1);
      tick();
      chk($sformatf("stream%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d.out", i), {24'd0, dout}, {24'd0, e});
    end
    in_valid = 1'b0;

    // Reset in the middle of a multiply: no result must ever appear.
    op = 4'd9; in0 = 8'd15; in1 = 8'd17; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_mul.out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst.out", {24'd0, dout}, 32'd0);
    chk("mid_rst.flags", {29'd0, zf, cf, err}, 32'd0);
    chk("mid_rst.in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("after_rst%0d.out_valid", c), {31'd0, out_valid}, 32'd0);
    end
    chk("after_rst.out", {24'd0, dout}, 32'd0);

    // Recovery: a fresh op completes normally.
    op = 4'd2; in0 = 8'd1; in1 = 8'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("recover.out_valid", {31'd0, out_valid}, 32'd1);
    chk("recover.out", {24'd0, dout}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
